// File: rtl/fixedpt_pkg.sv
// Shared fixed-point definitions for the rasterizer datapath (signed Q16.16).
package fixedpt_pkg;

    localparam int FP_WIDTH     = 32;
    localparam int FP_FRAC_BITS = 16;

    typedef logic signed [FP_WIDTH-1:0]   fixed_t;
    typedef logic signed [2*FP_WIDTH-1:0] fixed_wide_t;

    // Integer pixel/vertex coordinate to fixed point.
    function automatic fixed_t int_to_fixed(input int value);
        return fixed_t'(value) <<< FP_FRAC_BITS;
    endfunction

    // Fixed point back to integer, rounding toward minus infinity.
    function automatic int fixed_to_int(input fixed_t value);
        return int'(value >>> FP_FRAC_BITS);
    endfunction

    // Full-width product re-aligned to the binary point; nothing is dropped
    // from the integer part.
    function automatic fixed_wide_t fixed_mul(input fixed_t a, input fixed_t b);
        fixed_wide_t product;
        product = fixed_wide_t'(a) * fixed_wide_t'(b);
        return product >>> FP_FRAC_BITS;
    endfunction

endpackage

// File: rtl/edge_function_evaluator_if.sv
// Pixel-in / edge-values-out bus of the edge-function stage.
// Valid-only: i_write_enable qualifies every i_* field in the same cycle; the
// stage has no ready and accepts one pixel per cycle. o_write_pixel is the
// result valid gated by the inside test; o_* data fields change on every
// cycle a result leaves the pipeline and hold otherwise.
interface edge_function_evaluator_if
    import fixedpt_pkg::*;
#(
    parameter int WIDTH = FP_WIDTH
) ();

    logic                    i_write_enable;
    logic signed [15:0]      i_x_pos;
    logic signed [15:0]      i_y_pos;
    logic signed [WIDTH-1:0] i_vp_x;
    logic signed [WIDTH-1:0] i_vp_y;
    logic signed [WIDTH-1:0] i_v1_x;
    logic signed [WIDTH-1:0] i_v1_y;
    logic signed [WIDTH-1:0] i_v2_x;
    logic signed [WIDTH-1:0] i_v2_y;
    logic signed [WIDTH-1:0] i_v3_x;
    logic signed [WIDTH-1:0] i_v3_y;

    logic signed [15:0]      o_x_pos;
    logic signed [15:0]      o_y_pos;
    logic signed [WIDTH-1:0] o_area;
    logic signed [WIDTH-1:0] o_e1;
    logic signed [WIDTH-1:0] o_e2;
    logic signed [WIDTH-1:0] o_e3;
    logic                    o_write_pixel;

    // Bounding-box iterator side.
    modport master (
        output i_write_enable, i_x_pos, i_y_pos, i_vp_x, i_vp_y,
               i_v1_x, i_v1_y, i_v2_x, i_v2_y, i_v3_x, i_v3_y,
        input  o_x_pos, o_y_pos, o_area, o_e1, o_e2, o_e3, o_write_pixel
    );

    // Edge-function evaluator side.
    modport slave (
        input  i_write_enable, i_x_pos, i_y_pos, i_vp_x, i_vp_y,
               i_v1_x, i_v1_y, i_v2_x, i_v2_y, i_v3_x, i_v3_y,
        output o_x_pos, o_y_pos, o_area, o_e1, o_e2, o_e3, o_write_pixel
    );

endinterface

// File: rtl/edge_function_evaluator_term.sv
// One edge function E(a,b,p) = (p.x-a.x)*(b.y-a.y) - (p.y-a.y)*(b.x-a.x),
// two register stages deep; the final subtraction is left combinational so
// the parent can register both the truncated value and the inside decision
// in the same (third) stage.
module edge_term
    import fixedpt_pkg::*;
#(
    parameter int WIDTH     = FP_WIDTH,
    parameter int FRAC_BITS = FP_FRAC_BITS
) (
    input  logic                      i_clk,
    input  logic                      i_reset,
    input  logic signed [WIDTH-1:0]   i_a_x,
    input  logic signed [WIDTH-1:0]   i_a_y,
    input  logic signed [WIDTH-1:0]   i_b_x,
    input  logic signed [WIDTH-1:0]   i_b_y,
    input  logic signed [WIDTH-1:0]   i_p_x,
    input  logic signed [WIDTH-1:0]   i_p_y,
    output logic signed [2*WIDTH+2:0] o_result
);

    localparam int DW = WIDTH + 1;  // difference width, never overflows
    localparam int PW = 2 * DW;     // full product width
    localparam int RW = PW + 1;     // full-precision difference of products

    logic signed [DW-1:0] r_dpx;
    logic signed [DW-1:0] r_dby;
    logic signed [DW-1:0] r_dpy;
    logic signed [DW-1:0] r_dbx;

    logic signed [PW-1:0] w_dpx_ext;
    logic signed [PW-1:0] w_dby_ext;
    logic signed [PW-1:0] w_dpy_ext;
    logic signed [PW-1:0] w_dbx_ext;
    logic signed [PW-1:0] w_prod_a;
    logic signed [PW-1:0] w_prod_b;

    logic signed [PW-1:0] r_prod_a;
    logic signed [PW-1:0] r_prod_b;

    logic signed [RW-1:0] w_prod_a_ext;
    logic signed [RW-1:0] w_prod_b_ext;

    // Stage 1: sign-extended coordinate differences.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_dpx <= '0;
            r_dby <= '0;
            r_dpy <= '0;
            r_dbx <= '0;
        end else begin
            r_dpx <= {i_p_x[WIDTH-1], i_p_x} - {i_a_x[WIDTH-1], i_a_x};
            r_dby <= {i_b_y[WIDTH-1], i_b_y} - {i_a_y[WIDTH-1], i_a_y};
            r_dpy <= {i_p_y[WIDTH-1], i_p_y} - {i_a_y[WIDTH-1], i_a_y};
            r_dbx <= {i_b_x[WIDTH-1], i_b_x} - {i_a_x[WIDTH-1], i_a_x};
        end
    end

    assign w_dpx_ext = {{DW{r_dpx[DW-1]}}, r_dpx};
    assign w_dby_ext = {{DW{r_dby[DW-1]}}, r_dby};
    assign w_dpy_ext = {{DW{r_dpy[DW-1]}}, r_dpy};
    assign w_dbx_ext = {{DW{r_dbx[DW-1]}}, r_dbx};
    assign w_prod_a  = w_dpx_ext * w_dby_ext;
    assign w_prod_b  = w_dpy_ext * w_dbx_ext;

    // Stage 2: full products re-aligned to the binary point.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_prod_a <= '0;
            r_prod_b <= '0;
        end else begin
            r_prod_a <= w_prod_a >>> FRAC_BITS;
            r_prod_b <= w_prod_b >>> FRAC_BITS;
        end
    end

    assign w_prod_a_ext = {r_prod_a[PW-1], r_prod_a};
    assign w_prod_b_ext = {r_prod_b[PW-1], r_prod_b};
    assign o_result     = w_prod_a_ext - w_prod_b_ext;

endmodule

// File: rtl/edge_function_evaluator.sv
// Per-pixel edge-function stage: triangle area plus three edge functions,
// inside test on full-precision values, 3-cycle latency, 1 pixel/cycle.
module edge_function_evaluator
    import fixedpt_pkg::*;
#(
    parameter int WIDTH     = FP_WIDTH,
    parameter int FRAC_BITS = FP_FRAC_BITS
) (
    input  logic                     i_clk,
    input  logic                     i_reset,
    edge_function_evaluator_if.slave bus
);

    localparam int RW = 2 * WIDTH + 3;

    logic signed [RW-1:0] w_area;
    logic signed [RW-1:0] w_e1;
    logic signed [RW-1:0] w_e2;
    logic signed [RW-1:0] w_e3;
    logic                 w_all_nonneg;
    logic                 w_all_nonpos;
    logic                 w_inside;

    logic                 r_valid_s1;
    logic                 r_valid_s2;
    logic signed [15:0]   r_x_s1;
    logic signed [15:0]   r_y_s1;
    logic signed [15:0]   r_x_s2;
    logic signed [15:0]   r_y_s2;

    logic signed [15:0]      r_x_s3;
    logic signed [15:0]      r_y_s3;
    logic signed [WIDTH-1:0] r_area;
    logic signed [WIDTH-1:0] r_e1;
    logic signed [WIDTH-1:0] r_e2;
    logic signed [WIDTH-1:0] r_e3;
    logic                    r_write_pixel;

    // Signed area, E(v1,v2,v3).
    edge_term #(.WIDTH(WIDTH), .FRAC_BITS(FRAC_BITS)) u_area (
        .i_clk(i_clk), .i_reset(i_reset),
        .i_a_x(bus.i_v1_x), .i_a_y(bus.i_v1_y),
        .i_b_x(bus.i_v2_x), .i_b_y(bus.i_v2_y),
        .i_p_x(bus.i_v3_x), .i_p_y(bus.i_v3_y),
        .o_result(w_area)
    );

    // E(v2,v3,p).
    edge_term #(.WIDTH(WIDTH), .FRAC_BITS(FRAC_BITS)) u_e1 (
        .i_clk(i_clk), .i_reset(i_reset),
        .i_a_x(bus.i_v2_x), .i_a_y(bus.i_v2_y),
        .i_b_x(bus.i_v3_x), .i_b_y(bus.i_v3_y),
        .i_p_x(bus.i_vp_x), .i_p_y(bus.i_vp_y),
        .o_result(w_e1)
    );

    // E(v3,v1,p).
    edge_term #(.WIDTH(WIDTH), .FRAC_BITS(FRAC_BITS)) u_e2 (
        .i_clk(i_clk), .i_reset(i_reset),
        .i_a_x(bus.i_v3_x), .i_a_y(bus.i_v3_y),
        .i_b_x(bus.i_v1_x), .i_b_y(bus.i_v1_y),
        .i_p_x(bus.i_vp_x), .i_p_y(bus.i_vp_y),
        .o_result(w_e2)
    );

    // E(v1,v2,p).
    edge_term #(.WIDTH(WIDTH), .FRAC_BITS(FRAC_BITS)) u_e3 (
        .i_clk(i_clk), .i_reset(i_reset),
        .i_a_x(bus.i_v1_x), .i_a_y(bus.i_v1_y),
        .i_b_x(bus.i_v2_x), .i_b_y(bus.i_v2_y),
        .i_p_x(bus.i_vp_x), .i_p_y(bus.i_vp_y),
        .o_result(w_e3)
    );

    // Either winding is accepted; zero edges are inside, a zero area never is.
    assign w_all_nonneg = (w_e1 >= 0) && (w_e2 >= 0) && (w_e3 >= 0);
    assign w_all_nonpos = (w_e1 <= 0) && (w_e2 <= 0) && (w_e3 <= 0);
    assign w_inside     = ((w_area > 0) && w_all_nonneg) ||
                          ((w_area < 0) && w_all_nonpos);

    // Valid bit and pixel coordinates ride alongside the first two stages.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_valid_s1 <= 1'b0;
            r_valid_s2 <= 1'b0;
            r_x_s1     <= '0;
            r_y_s1     <= '0;
            r_x_s2     <= '0;
            r_y_s2     <= '0;
        end else begin
            r_valid_s1 <= bus.i_write_enable;
            r_valid_s2 <= r_valid_s1;
            r_x_s1     <= bus.i_x_pos;
            r_y_s1     <= bus.i_y_pos;
            r_x_s2     <= r_x_s1;
            r_y_s2     <= r_y_s1;
        end
    end

    // Stage 3: truncated results and the write strobe; data holds when idle.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_x_s3        <= '0;
            r_y_s3        <= '0;
            r_area        <= '0;
            r_e1          <= '0;
            r_e2          <= '0;
            r_e3          <= '0;
            r_write_pixel <= 1'b0;
        end else begin
            r_write_pixel <= r_valid_s2 && w_inside;
            if (r_valid_s2) begin
                r_x_s3 <= r_x_s2;
                r_y_s3 <= r_y_s2;
                r_area <= w_area[WIDTH-1:0];
                r_e1   <= w_e1[WIDTH-1:0];
                r_e2   <= w_e2[WIDTH-1:0];
                r_e3   <= w_e3[WIDTH-1:0];
            end
        end
    end

    assign bus.o_x_pos       = r_x_s3;
    assign bus.o_y_pos       = r_y_s3;
    assign bus.o_area        = r_area;
    assign bus.o_e1          = r_e1;
    assign bus.o_e2          = r_e2;
    assign bus.o_e3          = r_e3;
    assign bus.o_write_pixel = r_write_pixel;

endmodule

// File: tb/tb_edge_function_evaluator.sv
// Directed bench for the edge-function stage with hand-computed expectations.
module tb_edge_function_evaluator;
    import fixedpt_pkg::*;

    localparam int W     = FP_WIDTH;
    localparam int EXP_W = 16 + 16 + 4 * W + 1;

    logic i_clk;
    logic i_reset;

    edge_function_evaluator_if #(.WIDTH(W)) bus ();

    edge_function_evaluator #(.WIDTH(W), .FRAC_BITS(FP_FRAC_BITS)) dut (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .bus     (bus)
    );

    // ---------------- clock / reset ----------------
    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    // ---------------- scoreboard ----------------
    logic [EXP_W-1:0] exp_q[$];
    logic             pend[3];
    int               tests_run    = 0;
    int               tests_failed = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%h, expected 0x%h", tag, got, exp);
        end
    endtask

    // One clock edge, then compare whatever the expected pipeline says is due.
    task automatic tick();
        logic                    pres;
        logic [EXP_W-1:0]        e;
        logic signed [15:0]      ex;
        logic signed [15:0]      ey;
        logic signed [W-1:0]     ea;
        logic signed [W-1:0]     e1;
        logic signed [W-1:0]     e2;
        logic signed [W-1:0]     e3;
        logic                    ewp;
        pres = bus.i_write_enable && !i_reset;
        @(posedge i_clk);
        #1;
        if (i_reset) begin
            exp_q.delete();
            pend[0] = 1'b0;
            pend[1] = 1'b0;
            pend[2] = 1'b0;
            check_eq("rst_x",    bus.o_x_pos, 0);
            check_eq("rst_y",    bus.o_y_pos, 0);
            check_eq("rst_area", bus.o_area, 0);
            check_eq("rst_e1",   bus.o_e1, 0);
            check_eq("rst_e2",   bus.o_e2, 0);
            check_eq("rst_e3",   bus.o_e3, 0);
            check_eq("rst_wp",   bus.o_write_pixel, 0);
        end else begin
            pend[2] = pend[1];
            pend[1] = pend[0];
            pend[0] = pres;
            if (pend[2] && exp_q.size() > 0) begin
                e   = exp_q.pop_front();
                ex  = e[160:145];
                ey  = e[144:129];
                ea  = e[128:97];
                e1  = e[96:65];
                e2  = e[64:33];
                e3  = e[32:1];
                ewp = e[0];
                check_eq("x_pos", bus.o_x_pos, ex);
                check_eq("y_pos", bus.o_y_pos, ey);
                check_eq("area",  bus.o_area, ea);
                check_eq("e1",    bus.o_e1, e1);
                check_eq("e2",    bus.o_e2, e2);
                check_eq("e3",    bus.o_e3, e3);
                check_eq("write_pixel", bus.o_write_pixel, ewp);
            end else begin
                check_eq("wp_idle", bus.o_write_pixel, 0);
            end
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic set_tri(input int ax, input int ay, input int bx, input int by,
                           input int cx, input int cy);
        bus.i_v1_x = int_to_fixed(ax);
        bus.i_v1_y = int_to_fixed(ay);
        bus.i_v2_x = int_to_fixed(bx);
        bus.i_v2_y = int_to_fixed(by);
        bus.i_v3_x = int_to_fixed(cx);
        bus.i_v3_y = int_to_fixed(cy);
    endtask

    task automatic set_pixel(input int x, input int y);
        bus.i_x_pos = 16'(x);
        bus.i_y_pos = 16'(y);
        bus.i_vp_x  = int_to_fixed(x);
        bus.i_vp_y  = int_to_fixed(y);
    endtask

    task automatic send(input int x, input int y, input logic [W-1:0] ea,
                        input logic [W-1:0] e1, input logic [W-1:0] e2,
                        input logic [W-1:0] e3, input logic wp);
        logic [15:0] x16;
        logic [15:0] y16;
        x16 = 16'(x);
        y16 = 16'(y);
        set_pixel(x, y);
        bus.i_write_enable = 1'b1;
        exp_q.push_back({x16, y16, ea, e1, e2, e3, wp});
        tick();
    endtask

    task automatic idle();
        bus.i_write_enable = 1'b0;
        tick();
    endtask

    // ---------------- stimulus ----------------
    initial begin
        pend[0] = 1'b0;
        pend[1] = 1'b0;
        pend[2] = 1'b0;
        set_tri(0, 0, 10, 0, 0, 10);
        set_pixel(2, 2);

        // Reset with a pixel offered: nothing may enter the pipeline.
        i_reset            = 1'b1;
        bus.i_write_enable = 1'b1;
        tick();
        tick();
        i_reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            idle();
            check_eq("post_rst_area", bus.o_area, 0);
        end

        // Clockwise triangle: inside, outside, boundary.
        send(2, 2, int_to_fixed(-100), int_to_fixed(-60), int_to_fixed(-20), int_to_fixed(-20), 1'b1);
        send(8, 8, int_to_fixed(-100), int_to_fixed(60), int_to_fixed(-80), int_to_fixed(-80), 1'b0);
        send(5, 0, int_to_fixed(-100), int_to_fixed(-50), int_to_fixed(-50), int_to_fixed(0), 1'b1);

        // Opposite winding, issued back-to-back with the pixels above.
        set_tri(0, 0, 0, 10, 10, 0);
        send(2, 2, int_to_fixed(100), int_to_fixed(60), int_to_fixed(20), int_to_fixed(20), 1'b1);

        // Degenerate triangle: never inside, even with all-zero edges.
        set_tri(0, 0, 10, 0, 20, 0);
        send(2, 2, int_to_fixed(0), int_to_fixed(-20), int_to_fixed(40), int_to_fixed(-20), 1'b0);
        send(5, 0, int_to_fixed(0), int_to_fixed(0), int_to_fixed(0), int_to_fixed(0), 1'b0);

        // Large triangle: area -40000 and e1 -39600 wrap positive in 32 bits,
        // but the inside test must use the untruncated negative values.
        set_tri(0, 0, 200, 0, 0, 200);
        send(1, 1, 32'h63C0_0000, 32'h6550_0000, int_to_fixed(-200), int_to_fixed(-200), 1'b1);
        idle();
        idle();
        idle();

        // Streaming row, one idle gap, then one more pixel.
        set_tri(0, 0, 10, 0, 0, 10);
        for (int x = 0; x < 10; x++) begin
            send(x, 0, int_to_fixed(-100), int_to_fixed(10 * x - 100),
                 int_to_fixed(-10 * x), int_to_fixed(0), 1'b1);
        end
        idle();
        send(1, 1, int_to_fixed(-100), int_to_fixed(-80), int_to_fixed(-10), int_to_fixed(-10), 1'b1);
        idle();
        idle();
        idle();

        // Reset mid-stream: the last two pixels in flight are dropped.
        for (int x = 0; x < 4; x++) begin
            send(x, 0, int_to_fixed(-100), int_to_fixed(10 * x - 100),
                 int_to_fixed(-10 * x), int_to_fixed(0), 1'b1);
        end
        i_reset            = 1'b1;
        bus.i_write_enable = 1'b1;
        set_pixel(2, 2);
        tick();
        i_reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            idle();
        end

        check_eq("sb_drained", 64'(exp_q.size()), 0);

        // ---------------- report ----------------
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/edge_function_evaluator.md
Name: edge_function_evaluator

Overview:
- Pipelined per-pixel edge-function stage of the triangle rasterizer.
- For each pixel issued by the bounding-box iterator, computes the triangle's signed area and its three edge functions in fixed point.
- Flags whether the pixel lies inside the triangle.
- Forwards pixel coordinates, area and edge values to the barycentric-weight stage (EX1).

Parameters:
- WIDTH, 32, total bits of the signed fixed-point word.
- FRAC_BITS, 16, fractional bits (Q16.16).

Ports:
- i_clk  in  1  clock
- i_reset  in  1  synchronous, active-high reset
- i_write_enable  in  1  pixel valid this cycle
- i_x_pos  in  16 signed  integer pixel x, passed through
- i_y_pos  in  16 signed  integer pixel y, passed through
- i_vp_x, i_vp_y  in  WIDTH signed  pixel position in fixed point (integer << FRAC_BITS)
- i_v1_x, i_v1_y, i_v2_x, i_v2_y, i_v3_x, i_v3_y  in  WIDTH signed  vertex coordinates, fixed point
- o_x_pos, o_y_pos  out  16 signed  pixel coordinates aligned with the results
- o_area  out  WIDTH signed  E(v1,v2,v3)
- o_e1  out  WIDTH signed  E(v2,v3,p)
- o_e2  out  WIDTH signed  E(v3,v1,p)
- o_e3  out  WIDTH signed  E(v1,v2,p)
- o_write_pixel  out  1  result valid and pixel inside

Behaviour:
- Edge function: E(a,b,p) = (p.x-a.x)*(b.y-a.y) - (p.y-a.y)*(b.x-a.x).
- Arithmetic width rules:
  - Differences are computed at WIDTH+1 bits.
  - Products are full 2*(WIDTH+1) bits, then arithmetic-shifted right by FRAC_BITS.
  - Subtraction is kept at full precision internally.
  - Outputs are the low WIDTH bits (truncation, no saturation).
- 3-stage pipeline, latency 3 cycles, throughput 1 pixel/cycle, no stall or backpressure:
  - S1 registers all coordinate differences, the valid bit and x/y.
  - S2 registers the eight products.
  - S3 registers area/e1/e2/e3, x/y and o_write_pixel.
- Vertex and vp inputs are sampled in S1 on every cycle. Vertices may change between pixels without corrupting pixels already in flight.
- Inside test is evaluated on the full-precision values, never on truncated ones:
  - Inside if area>0 and e1,e2,e3 all >=0, or area<0 and e1,e2,e3 all <=0.
  - Both windings are accepted.
  - Zero edge values count as inside (no top-left rule).
  - area==0 (degenerate triangle) is never inside.
- o_write_pixel = S3 valid AND inside. The data outputs update every cycle S3 is valid, whether or not the pixel is inside.
- Reset:
  - All valid bits clear and all outputs go to 0 on the next edge.
  - Pixels in flight are discarded.
  - i_write_enable asserted during reset is ignored.
- Reset deasserted: first o_write_pixel can appear no earlier than 3 cycles after the first accepted i_write_enable.
- Back-to-back pixels produce back-to-back results in the same order. Gaps in i_write_enable propagate as gaps in o_write_pixel.

Decomposition:
- Shared package fixedpt_pkg holds:
  - WIDTH and FRAC_BITS constants;
  - the fixed-point word typedef;
  - int-to-fixed and fixed-to-int conversion functions;
  - a fixed multiply function (full product, arithmetic shift by FRAC_BITS).
- One natural sub-module: edge_term, a pipelined single edge function.
  - Inputs a, b, p; outputs the full-precision result.
  - Instantiated four times (area, e1, e2, e3); the top adds the valid/coordinate delay line and the inside test.

Test Plan:
- Reset: drive i_reset with i_write_enable=1 for 2 cycles -> all outputs 0, o_write_pixel=0 for 3 cycles after release.
- Triangle v1=(0,0), v2=(10,0), v3=(0,10), pixel (2,2) at cycle t:
  - at t+3, o_area=-100 (0xFF9C0000), o_e1=-60, o_e2=-20, o_e3=-20;
  - o_write_pixel=1, o_x_pos=2, o_y_pos=2.
- Same triangle, pixel (8,8) -> o_e1=+60, o_write_pixel=0; data outputs still valid values.
- Same triangle, boundary pixel (5,0) -> o_e3=0, o_e1=-50, o_e2=-50, o_write_pixel=1. Then swap v2 and v3 (opposite winding) -> area=+100, o_e1=+60 / o_e2=+20 / o_e3=+20 at (2,2), o_write_pixel=1.
- Degenerate: v3=(20,0), any pixel -> o_area=0, o_write_pixel never asserted.
- Streaming: pixels (0,0)..(9,0) on 10 consecutive cycles, then one idle cycle, then (1,1) -> 10 consecutive in-order results starting 3 cycles later, one gap, then (1,1) inside. Asserting reset mid-stream discards the remaining pixels.
